// File: rtl/io_port_ctrl.sv
// CPU-facing io port controller: RAM pass-through, UART-RX read, UART-TX FIFO,
// free-running cycle counter with coherent 4-byte snapshot, sticky program-finish flag.
module io_port_ctrl #(
  parameter int TX_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_finish
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [15:0] OFF_RX  = 16'h0000;
  localparam logic [15:0] OFF_CNT = 16'h0004;

  // Address decode
  logic        is_io;
  logic [15:0] io_off;
  logic        io_rd;
  logic        io_wr;
  logic        rd_rx;
  logic        rd_cnt;
  logic        rd_snap;
  logic        unused_addr_bits;

  assign is_io            = (mem_a[17:16] == 2'b11);
  assign io_off           = mem_a[15:0];
  assign io_rd            = rdy_in & is_io & ~mem_wr;
  assign io_wr            = rdy_in & is_io & mem_wr;
  assign rd_rx            = io_rd & (io_off == OFF_RX);
  assign rd_cnt           = io_rd & (io_off == OFF_CNT);
  assign rd_snap          = io_rd & (io_off[15:2] == 14'h0001) & (io_off[1:0] != 2'b00);
  assign unused_addr_bits = ^mem_a[31:18];

  assign ram_a     = mem_a[16:0];
  assign ram_wdata = mem_dout;
  assign ram_we    = rdy_in & mem_wr & ~is_io;

  // Read return path and cycle counter
  logic        sel_io_q;
  logic [7:0]  io_rdata_q;
  logic [7:0]  io_rdata_d;
  logic [31:0] cycle_cnt;
  logic [31:0] snap_q;

  assign rx_pop = rd_rx & rx_valid;

  // Byte 0 comes from the live counter so it matches the value captured into snap_q.
  always_comb begin
    io_rdata_d = 8'h00;
    if (rd_rx) begin
      io_rdata_d = rx_valid ? rx_data : 8'h00;
    end else if (rd_cnt) begin
      io_rdata_d = cycle_cnt[7:0];
    end else if (rd_snap) begin
      io_rdata_d = snap_q[{io_off[1:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_io_q   <= 1'b0;
      io_rdata_q <= 8'h00;
      cycle_cnt  <= 32'h0000_0000;
      snap_q     <= 32'h0000_0000;
    end else if (rdy_in) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      sel_io_q  <= is_io & ~mem_wr;
      if (io_rd) begin
        io_rdata_q <= io_rdata_d;
      end
      if (rd_cnt) begin
        snap_q <= cycle_cnt;
      end
    end
  end

  assign mem_din = sel_io_q ? io_rdata_q : ram_rdata;

  // Write decode; everything is locked out once the program has finished.
  logic       wr_ok;
  logic       wr_char;
  logic       wr_fin;
  logic       push_req;
  logic [7:0] push_data;

  assign wr_ok     = io_wr & ~program_finish;
  assign wr_char   = wr_ok & (io_off == OFF_RX) & (mem_dout != 8'h00);
  assign wr_fin    = wr_ok & (io_off == OFF_CNT);
  assign push_req  = wr_char | wr_fin;
  assign push_data = wr_fin ? 8'h00 : mem_dout;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      program_finish <= 1'b0;
    end else if (wr_fin) begin
      program_finish <= 1'b1;
    end
  end

  // TX FIFO. Stream handshake: a byte moves on a rising edge where tx_valid and
  // tx_ready are both high; tx_data is stable while tx_valid waits for tx_ready.
  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          push;
  logic          pop;

  assign fifo_full      = (count == CW'(TX_DEPTH));
  assign tx_valid       = (count != '0);
  assign tx_data        = fifo_mem[rd_ptr];
  assign pop            = tx_valid & tx_ready;
  assign push           = push_req & (~fifo_full | pop);
  assign io_buffer_full = (count >= CW'(TX_DEPTH - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

endmodule
